// File: rtl/pipeline_run_controller_if.sv
// Signal bundle between the run controller and whatever drives/observes it
// (board harness or bench): run request, retire stream, halt setup and run results.
interface pipeline_run_controller_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 retire_valid;
  logic [PC_WIDTH-1:0]  retire_pc;
  logic                 halt_en;
  logic [PC_WIDTH-1:0]  halt_pc;
  logic                 core_rst;
  logic                 running;
  logic                 done;
  logic [1:0]           status;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] retire_count;

  modport master (
    output start, retire_valid, retire_pc, halt_en, halt_pc,
    input  core_rst, running, done, status, cycle_count, retire_count
  );

  modport slave (
    input  start, retire_valid, retire_pc, halt_en, halt_pc,
    output core_rst, running, done, status, cycle_count, retire_count
  );
endinterface

// File: rtl/pipeline_run_controller.sv
// Run/reset sequencer for the pipelined core: holds the core in reset, runs it, counts
// cycles/retires and ends the run on halt PC, retire stall or cycle timeout.
module pipeline_run_controller #(
  parameter int RST_HOLD_CYCLES = 2,
  parameter int MAX_CYCLES      = 500,
  parameter int IDLE_LIMIT      = 16,
  parameter int PC_WIDTH        = 32,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  pipeline_run_controller_if.slave     bus
);

  localparam longint CNT_LIMIT = (longint'(1) << CNT_WIDTH) - longint'(1);

  if ((MAX_CYCLES < 1) || (longint'(MAX_CYCLES) > CNT_LIMIT) || (RST_HOLD_CYCLES < 1)) begin : g_param_check
    $fatal(1, "pipeline_run_controller: illegal MAX_CYCLES/RST_HOLD_CYCLES");
  end

  localparam int                   HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_INIT = HOLD_W'(RST_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CYC_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_LIMIT - 1);
  localparam bit                   STALL_EN  = (IDLE_LIMIT != 0);

  localparam logic [1:0] STAT_NONE    = 2'b00;
  localparam logic [1:0] STAT_HALT    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;
  localparam logic [1:0] STAT_STALL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;
  logic [1:0]           status_q, status_d;
  logic                 core_rst_q, core_rst_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;

  logic [PC_WIDTH-1:0]  retire_pc_s;
  logic [PC_WIDTH-1:0]  halt_pc_s;
  logic                 ev_halt_s;
  logic                 ev_stall_s;
  logic                 ev_timeout_s;

  assign retire_pc_s  = bus.retire_pc;
  assign halt_pc_s    = bus.halt_pc;
  assign ev_halt_s    = bus.halt_en && bus.retire_valid && (retire_pc_s == halt_pc_s);
  assign ev_stall_s   = STALL_EN && !bus.retire_valid && (idle_cnt_q == IDLE_LAST);
  assign ev_timeout_s = (cycle_cnt_q == CYC_LAST);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
      idle_cnt_q   <= '0;
      status_q     <= STAT_NONE;
      core_rst_q   <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      status_q     <= status_d;
      core_rst_q   <= core_rst_d;
      running_q    <= running_d;
      done_q       <= done_d;
    end
  end

  // Next state, counters and latched status.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    status_d     = status_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_HOLD;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_ONE) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
        end
      end
      ST_RUN: begin
        cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        if (bus.retire_valid) begin
          idle_cnt_d   = '0;
          retire_cnt_d = (retire_cnt_q == CNT_MAX) ? retire_cnt_q : retire_cnt_q + CNT_ONE;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_ONE;
        end
        // Counters above still include the terminating cycle.
        if (ev_halt_s) begin
          state_d  = ST_DONE;
          status_d = STAT_HALT;
        end else if (ev_stall_s) begin
          state_d  = ST_DONE;
          status_d = STAT_STALL;
        end else if (ev_timeout_s) begin
          state_d  = ST_DONE;
          status_d = STAT_TIMEOUT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_HOLD;
          hold_cnt_d   = HOLD_INIT;
          cycle_cnt_d  = '0;
          retire_cnt_d = '0;
          idle_cnt_d   = '0;
          status_d     = STAT_NONE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode; core reset releases one cycle after RUN is entered.
  always_comb begin
    core_rst_d = 1'b0;
    running_d  = 1'b0;
    done_d     = 1'b0;
    case (state_d)
      ST_RUN: begin
        running_d  = 1'b1;
        core_rst_d = (state_q == ST_RUN);
      end
      ST_DONE: begin
        done_d     = 1'b1;
        core_rst_d = 1'b1;
      end
      default: begin
        core_rst_d = 1'b0;
      end
    endcase
  end

  assign bus.core_rst     = core_rst_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.status       = status_q;
  assign bus.cycle_count  = cycle_cnt_q;
  assign bus.retire_count = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Scoreboard bench for pipeline_run_controller: runs are described as per-cycle retire
// patterns, a reference model predicts the run result, and a monitor checks it at done.
module tb_pipeline_run_controller;

  localparam int RST_HOLD = 2;
  localparam int MAXC     = 50;
  localparam int IDLE_LIM = 16;
  localparam int PCW      = 32;
  localparam int CW       = 16;

  typedef struct {
    logic [1:0] st;
    int         cyc;
    int         ret;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   passes;
  exp_t sb_q[$];

  bit          pat_v  [1:MAXC+2];
  logic [31:0] pat_pc [1:MAXC+2];

  pipeline_run_controller_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CW)) bus ();

  pipeline_run_controller #(
    .RST_HOLD_CYCLES(RST_HOLD),
    .MAX_CYCLES     (MAXC),
    .IDLE_LIMIT     (IDLE_LIM),
    .PC_WIDTH       (PCW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: walk the retire pattern cycle by cycle, first event wins, halt > stall > timeout.
  function automatic exp_t model_run(input bit en, input logic [31:0] hpc);
    exp_t e;
    int   idle_run;
    bit   fin;
    e.st = 2'b00; e.cyc = 0; e.ret = 0;
    idle_run = 0; fin = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      if (!fin) begin
        e.cyc = c;
        if (pat_v[c]) begin e.ret++; idle_run = 0; end
        else idle_run++;
        if (pat_v[c] && en && pat_pc[c] == hpc) begin e.st = 2'b01; fin = 1'b1; end
        else if (IDLE_LIM != 0 && idle_run == IDLE_LIM) begin e.st = 2'b11; fin = 1'b1; end
        else if (c == MAXC) begin e.st = 2'b10; fin = 1'b1; end
      end
    end
    return e;
  endfunction

  task automatic clear_pat();
    for (int c = 1; c <= MAXC + 2; c++) begin
      pat_v[c]  = 1'b0;
      pat_pc[c] = 32'h0;
    end
  endtask

  function automatic logic [63:0] outs();
    return {26'd0, bus.core_rst, bus.running, bus.done, bus.status, bus.cycle_count, bus.retire_count};
  endfunction

  task automatic run_case(input bit en, input logic [31:0] hpc);
    bit got_done;
    sb_q.push_back(model_run(en, hpc));
    @(negedge clk);
    bus.halt_en      = en;
    bus.halt_pc      = hpc;
    bus.start        = 1'b1;
    bus.retire_valid = 1'($urandom_range(0, 1));
    bus.retire_pc    = hpc;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check(outs() == 64'd0, "restart_clear", outs(), 64'd0);
    // Retires during HOLD must be ignored.
    repeat (RST_HOLD) begin
      bus.retire_valid = 1'($urandom_range(0, 1));
      bus.retire_pc    = hpc;
      @(posedge clk);
    end
    got_done = 1'b0;
    for (int c = 1; c <= MAXC + 2; c++) begin
      @(negedge clk);
      if (c == 1) check(!bus.core_rst && bus.running, "core_rst_hold", {62'd0, bus.core_rst, bus.running}, 64'd1);
      if (c == 2) check(bus.core_rst, "core_rst_rise", {63'd0, bus.core_rst}, 64'd1);
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      bus.retire_valid = pat_v[c];
      bus.retire_pc    = pat_pc[c];
    end
    if (!got_done) check(1'b0, "run_timeout", 64'd0, 64'd1);
    bus.retire_valid = 1'b0;
  endtask

  // Monitor: on each rising done, compare the result against the oldest prediction.
  initial begin : monitor
    bit   done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done && !done_prev) begin
        if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check(bus.status == e.st, "status", 64'(bus.status), 64'(e.st));
          check(int'(bus.cycle_count) == e.cyc, "cycle_count", 64'(bus.cycle_count), 64'(e.cyc));
          check(int'(bus.retire_count) == e.ret, "retire_count", 64'(bus.retire_count), 64'(e.ret));
          check(!bus.running && bus.core_rst, "done_outputs", {62'd0, bus.running, bus.core_rst}, 64'd1);
        end
      end
      done_prev = bus.done;
    end
  end

  initial begin : stimulus
    int dens;
    checks = 0;
    passes = 0;
    rst = 1'b0;
    bus.start = 1'b0; bus.retire_valid = 1'b0; bus.retire_pc = 32'h0;
    bus.halt_en = 1'b0; bus.halt_pc = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bus.retire_valid = 1'($urandom_range(0, 1));
      check(outs() == 64'd0, "idle_quiet", outs(), 64'd0);
    end
    bus.retire_valid = 1'b0;

    // Halt after five consecutive retires starting at run cycle 5.
    clear_pat();
    for (int c = 5; c <= 9; c++) begin pat_v[c] = 1'b1; pat_pc[c] = 32'((c - 5) * 4); end
    run_case(1'b1, 32'h10);

    // Timeout with a retire every cycle.
    clear_pat();
    for (int c = 1; c <= MAXC + 2; c++) begin pat_v[c] = 1'b1; pat_pc[c] = 32'(c * 4); end
    run_case(1'b0, 32'h0);

    // Stall after three retires.
    clear_pat();
    for (int c = 1; c <= 3; c++) begin pat_v[c] = 1'b1; pat_pc[c] = 32'(c * 4); end
    run_case(1'b1, 32'hFFFF_FFF0);

    // Halt on cycle MAX-1 and on cycle MAX (halt beats timeout).
    clear_pat();
    for (int c = 1; c <= MAXC + 2; c++) begin pat_v[c] = 1'b1; pat_pc[c] = 32'(c * 4); end
    run_case(1'b1, 32'((MAXC - 1) * 4));
    run_case(1'b1, 32'(MAXC * 4));

    // Stall landing on the last cycle (stall beats timeout).
    clear_pat();
    for (int c = 1; c <= MAXC - IDLE_LIM; c++) begin pat_v[c] = 1'b1; pat_pc[c] = 32'h4; end
    run_case(1'b1, 32'h8);

    // Asynchronous reset in the middle of a run.
    clear_pat();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (RST_HOLD + 6) begin
      @(negedge clk);
      bus.retire_valid = 1'b1;
    end
    #2 rst = 1'b0;
    #1 check(outs() == 64'd0, "async_reset", outs(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.retire_valid = 1'b0;
    repeat (3) @(negedge clk);
    check(outs() == 64'd0, "idle_after_reset", outs(), 64'd0);

    // Randomized runs, each starting from DONE of the previous one.
    for (int r = 0; r < 24; r++) begin
      clear_pat();
      dens = $urandom_range(0, 4);
      for (int c = 1; c <= MAXC + 2; c++) begin
        pat_v[c]  = ($urandom_range(0, 3) < dens);
        pat_pc[c] = 32'($urandom_range(0, 23) * 4);
      end
      run_case(1'($urandom_range(0, 1)), 32'($urandom_range(0, 23) * 4));
    end

    repeat (4) @(negedge clk);
    check(sb_q.size() == 0, "scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
